// File: rtl/mult_pkg.sv
// Shared constants, FSM state encoding and operand helper for the sequential 32x32 multiplier.
package mult_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Two's complement magnitude; -2^31 maps onto unsigned 0x80000000.
  function automatic logic [OP_W-1:0] op_magnitude(input logic [OP_W-1:0] x);
    return x[OP_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mux_64bit.sv
// 64-bit 2:1 multiplexer; s=1 selects b.
module mux_64bit (
  output logic [63:0] out,
  input  logic        s,
  input  logic [63:0] a,
  input  logic [63:0] b
);

  assign out = s ? b : a;

endmodule

// File: rtl/mult_32bit_seq.sv
// Sequential shift-add 32x32 -> 64 multiplier, one partial product per cycle.
// Define SIGNED_MULT_EN for two's complement operands (adds the FIX sign-correction state).
module mult_32bit_seq
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    mcand_q, mcand_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_a, op_b;
  logic [OP_W:0]      sum;
  logic [PROD_W-1:0]  shift_nadd, shift_add, shift_sel;

`ifdef SIGNED_MULT_EN
  logic sign_q, sign_d;

  assign op_a = op_magnitude(multiplicand);
  assign op_b = op_magnitude(multiplier);
`else
  assign op_a = multiplicand;
  assign op_b = multiplier;
`endif

  // Carry out of the upper-half add lands in product[63] after the shift.
  assign sum        = {1'b0, prod_q[PROD_W-1:OP_W]} + {1'b0, mcand_q};
  assign shift_nadd = {1'b0, prod_q[PROD_W-1:1]};
  assign shift_add  = {sum, prod_q[OP_W-1:1]};

  mux_64bit u_mux (
    .out (shift_sel),
    .s   (prod_q[0]),
    .a   (shift_nadd),
    .b   (shift_add)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`ifdef SIGNED_MULT_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d = op_a;
          prod_d  = {{OP_W{1'b0}}, op_b};
          cnt_d   = '0;
          state_d = StRun;
`ifdef SIGNED_MULT_EN
          sign_d  = multiplicand[OP_W-1] ^ multiplier[OP_W-1];
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        prod_d = shift_sel;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == '1) begin
`ifdef SIGNED_MULT_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end
      StFix: begin
`ifdef SIGNED_MULT_EN
        if (sign_q) prod_d = ~prod_q + 1'b1;
        state_d = StDone;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`ifdef SIGNED_MULT_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`ifdef SIGNED_MULT_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign product = prod_q;
  assign busy    = (state_q == StRun) || (state_q == StFix);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Scoreboard bench for mult_32bit_seq: stimulus pushes expected results, a monitor checks on done.
module tb_mult_32bit_seq;

`ifdef SIGNED_MULT_EN
  localparam int Lat = 33;
`else
  localparam int Lat = 32;
`endif

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        busy;
  logic        done;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mult_32bit_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge; inputs are scrambled afterwards since they must not matter.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    sb_q.push_back('{exp, cyc + 1 + Lat});
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got done=%b expected 1 within 40 cycles", name, done);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("product", product, mon_e.prod);
        check("done_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [63:0] vp [4];

  initial begin
    va[0] = 32'h0000_0000; vb[0] = 32'hDEAD_BEEF; vp[0] = 64'h0;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'h0000_0005;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vp[2] = 64'h4000_0000_0000_0000;
    va[3] = 32'h0001_0000; vb[3] = 32'h0000_FFFF; vp[3] = 64'h0000_0000_FFFF_0000;
`ifdef SIGNED_MULT_EN
    vp[1] = 64'hFFFF_FFFF_FFFF_FFF1;
`else
    vp[1] = 64'h0000_0004_FFFF_FFF1;
`endif

    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    tick();
    tick();
    check("reset_product", product, 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    reset = 1'b0;
    tick();

    issue(32'd3, 32'd5, 64'hF);
    check("busy_running", 64'(busy), 64'h1);
    wait_done("mul_3x5");
    tick();
    check("busy_after_done", 64'(busy), 64'h0);
    check("done_one_cycle", 64'(done), 64'h0);
    repeat (3) tick();
    check("product_held_idle", product, 64'hF);

`ifdef SIGNED_MULT_EN
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
`else
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
`endif
    wait_done("mul_max");
    tick();

    issue(32'd7, 32'd9, 64'h3F);
    repeat (9) tick();
    start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
    tick();
    start = 1'b0;
    check("busy_ignore_start", 64'(busy), 64'h1);
    wait_done("mul_ignore");
    tick();

    issue(32'd7, 32'd9, 64'h3F);
    repeat (14) tick();
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    check("abort_product", product, 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    tick();
    issue(32'd6, 32'd7, 64'h2A);
    wait_done("mul_after_abort");
    tick();

    issue(32'd5, 32'd6, 64'h1E);
    wait_done("mul_b2b_first");
    issue(32'd4, 32'd4, 64'h10);
    check("b2b_done_low", 64'(done), 64'h0);
    check("b2b_busy", 64'(busy), 64'h1);
    wait_done("mul_b2b_second");
    tick();

    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vp[i]);
      wait_done("mul_table");
      tick();
    end

    for (int n = 0; n < 50 && sb_q.size() > 0; n++) tick();
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d outstanding results expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
